ppad_port_sched: RTL and testbench
==================================

// Module: ppad_port_sched
// PURPOSE
// Schedules the psum pad (PPad) ports of one PE between three requesters: MAIN (random-address
// accumulation reads), SS (stage-in writes) and PS (path-stage drain reads). The pad has one
// read and one write port per cycle. SS writes and PS reads are sequenced as a circular FIFO
// over the first i_size pad entries. This prevents PS from outrunning SS and SS from
// overwriting undrained entries. MAIN and PS share the read port under starvation-bounded
// priority.
// PARAMETERS
// ADDRWD      5   pad address width; DEPTH = 2**ADDRWD entries
// STARVE_MAX  4   consecutive lost read cycles before PS is forced to win the read port
// PASSWD      8   width of pass counter / i_npass
// PORTS
// i_clk        in   1          clock
// i_rst        in   1          synchronous, active-high reset
// i_inst_reset in   1          PE soft reset: return to IDLE
// i_stall      in   1          PE stall
// i_start      in   1          start job; latches i_size, i_npass (IDLE only)
// i_size       in   ADDRWD+1   entries per pass, legal 1..DEPTH (0 treated as 1, >DEPTH as DEPTH)
// i_npass      in   PASSWD     passes to drain before done (0 treated as 1)
// MAIN_rdy     in   1          MAIN read request
// MAIN_ack     out  1          MAIN granted this cycle
// i_main_raddr in   ADDRWD     MAIN read address
// SS_rdy       in   1          SS write request
// SS_ack       out  1          SS write accepted this cycle
// PS_rdy       in   1          PS read request
// PS_ack       out  1          PS read granted this cycle
// o_rd         out  1          pad read enable
// o_raddr      out  ADDRWD     pad read address
// o_wr         out  1          pad write enable
// o_waddr      out  ADDRWD     pad write address (= wptr)
// o_rsel       out  2          registered read-data owner: 01 MAIN, 10 PS, 00 none
// o_ps_addr    out  ADDRWD     current PS drain address (= rptr)
// o_done       out  1          one-cycle pulse: final pass drained
// BEHAVIOUR
// - States: IDLE, RUN, STALL. All outputs 0 in IDLE/reset, except MAIN_ack and o_rd/o_raddr when MAIN is served.
// - IDLE -> RUN on i_start: size_r, npass_r latched and clamped; ptrs, pass bits, counters cleared.
// - RUN -> STALL when i_stall; STALL -> RUN when !i_stall. Any state -> IDLE on i_inst_reset.
// - RUN -> IDLE when the final PS read of pass npass_r is acked; o_done pulses in that same cycle.
// - wptr/rptr range 0..size_r-1, each with a pass bit. A pointer wraps to 0 and toggles its pass bit on
//   an accepted op at size_r-1.
// - empty = (wptr==rptr && bits equal); full = (wptr==rptr && bits differ).
// - SS_ack = SS_rdy && state==RUN && !full. o_wr = SS_ack; o_waddr = wptr.
// - PS eligible = PS_rdy && state==RUN && !empty.
// - Read port:
//   - MAIN wins over PS unless starve_cnt==STARVE_MAX.
//   - starve_cnt increments per cycle PS is eligible but loses. It clears on a PS grant, in IDLE, and on reset.
//   - MAIN is served in every state, including STALL and IDLE.
// - MAIN_ack/PS_ack are combinational same-cycle responses to rdy; at most one is high.
// - o_rd = MAIN_ack||PS_ack. o_raddr = i_main_raddr on MAIN grant, rptr on PS grant.
// - o_rsel is registered: it carries the grant one cycle later, matching pad read latency 1.
// - A simultaneous SS write and PS read is legal. Both pointers advance; occupancy is unchanged.
//   - When full, SS is blocked even if PS drains in that cycle; SS is accepted next cycle.
//   - When empty, PS is blocked even if SS writes in that cycle; there is no write-to-read bypass.
// - Pass counter: increments each time rptr wraps. Done when it reaches npass_r.
// - i_inst_reset or i_rst mid-job: pointers, counters and o_rsel clear next cycle; no o_done.
// - Pointer arithmetic: compare before increment; wrap uses size_r-1, never DEPTH-1 implicitly.
// TESTING
// - size=4,npass=1: SS 4 writes, then PS 4 reads -> waddr 0..3, raddr 0..3, o_done on 4th PS_ack, IDLE.
// - size=2: SS writes 2 with PS idle -> 3rd SS_rdy gets SS_ack=0 (full). 1 PS read -> SS_ack=1 next cycle at waddr 0.
// - MAIN_rdy held with PS eligible, STARVE_MAX=4 -> MAIN granted 4 cycles, PS on 5th; o_rsel=10 one cycle later.
// - PS_rdy while empty alongside SS write -> PS_ack=0 that cycle, PS_ack=1 next cycle raddr 0.
// - i_stall mid-pass -> SS_ack/PS_ack 0, MAIN still acked. Release -> resumes at same wptr/rptr.
// - i_inst_reset after 3 of 8 entries (size=8) -> IDLE next cycle, no o_done. New i_start restarts at ptr 0.

Source files
------------

// File: rtl/ppad_port_sched.sv
// ppad_port_sched: psum pad port scheduler for one PE.
//   Arbitrates the pad's single read port between MAIN (random-address reads)
//   and PS (path-stage drain reads), and gives SS (stage-in writes) the write
//   port. SS writes and PS reads walk a circular FIFO over the first size
//   entries of the pad; a pass bit per pointer separates full from empty.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_inst_reset        PE soft reset back to IDLE
//   i_stall             PE stall (RUN <-> STALL)
//   i_start/i_size/i_npass  job start with entries per pass and pass count
//   MAIN_rdy/MAIN_ack/i_main_raddr  MAIN read request, grant, address
//   SS_rdy/SS_ack       SS write request / accept
//   PS_rdy/PS_ack       PS read request / grant
//   o_rd/o_raddr        pad read enable / address
//   o_wr/o_waddr        pad write enable / address
//   o_rsel              registered read-data owner (01 MAIN, 10 PS)
//   o_ps_addr           current PS drain address
//   o_done              pulse when the final pass has drained
module ppad_port_sched #(
    parameter int unsigned ADDRWD     = 5,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned PASSWD     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inst_reset,
    input  logic              i_stall,
    input  logic              i_start,
    input  logic [ADDRWD:0]   i_size,
    input  logic [PASSWD-1:0] i_npass,
    input  logic              MAIN_rdy,
    output logic              MAIN_ack,
    input  logic [ADDRWD-1:0] i_main_raddr,
    input  logic              SS_rdy,
    output logic              SS_ack,
    input  logic              PS_rdy,
    output logic              PS_ack,
    output logic              o_rd,
    output logic [ADDRWD-1:0] o_raddr,
    output logic              o_wr,
    output logic [ADDRWD-1:0] o_waddr,
    output logic [1:0]        o_rsel,
    output logic [ADDRWD-1:0] o_ps_addr,
    output logic              o_done
);

    localparam int unsigned DEPTH = 1 << ADDRWD;
    localparam int unsigned SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDRWD:0]   size_q, size_d;
    logic [PASSWD-1:0] npass_q, npass_d;
    logic [PASSWD-1:0] pass_q, pass_d;
    logic [ADDRWD-1:0] wptr_q, wptr_d;
    logic [ADDRWD-1:0] rptr_q, rptr_d;
    logic              wbit_q, wbit_d;
    logic              rbit_q, rbit_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [1:0]        rsel_q, rsel_d;

    logic              run;
    logic              empty;
    logic              full;
    logic [ADDRWD-1:0] last_idx;
    logic              w_wrap;
    logic              r_wrap;
    logic              ss_ack;
    logic              ps_elig;
    logic              ps_force;
    logic              main_ack;
    logic              ps_ack;
    logic              final_rd;
    logic              done;
    logic [ADDRWD:0]   size_in;
    logic [PASSWD-1:0] npass_in;

    // Grants and FIFO status
    always_comb begin
        run      = (state_q == ST_RUN);
        empty    = (wptr_q == rptr_q) && (wbit_q == rbit_q);
        full     = (wptr_q == rptr_q) && (wbit_q != rbit_q);
        last_idx = ADDRWD'(size_q - 1'b1);
        w_wrap   = (wptr_q == last_idx);
        r_wrap   = (rptr_q == last_idx);
        ss_ack   = SS_rdy && run && !full;
        ps_elig  = PS_rdy && run && !empty;
        // Once PS has lost STARVE_MAX eligible cycles in a row it takes the port.
        ps_force = ps_elig && (starve_q == SW'(STARVE_MAX));
        main_ack = MAIN_rdy && !ps_force;
        ps_ack   = ps_elig && !main_ack;
        final_rd = ps_ack && r_wrap && ((pass_q + 1'b1) == npass_q);
        done     = final_rd && !i_inst_reset;

        if (i_size == '0) begin
            size_in = (ADDRWD + 1)'(1);
        end else if (i_size > (ADDRWD + 1)'(DEPTH)) begin
            size_in = (ADDRWD + 1)'(DEPTH);
        end else begin
            size_in = i_size;
        end
        npass_in = (i_npass == '0) ? PASSWD'(1) : i_npass;
    end

    // Next-state
    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        npass_d  = npass_q;
        pass_d   = pass_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        wbit_d   = wbit_q;
        rbit_d   = rbit_q;
        starve_d = starve_q;
        rsel_d   = {ps_ack, main_ack};

        case (state_q)
            ST_IDLE: begin
                pass_d   = '0;
                wptr_d   = '0;
                rptr_d   = '0;
                wbit_d   = 1'b0;
                rbit_d   = 1'b0;
                starve_d = '0;
                if (i_start) begin
                    state_d = ST_RUN;
                    size_d  = size_in;
                    npass_d = npass_in;
                end
            end
            ST_RUN, ST_STALL: begin
                if (ss_ack) begin
                    wptr_d = w_wrap ? '0 : wptr_q + 1'b1;
                    wbit_d = wbit_q ^ w_wrap;
                end
                if (ps_ack) begin
                    rptr_d = r_wrap ? '0 : rptr_q + 1'b1;
                    rbit_d = rbit_q ^ r_wrap;
                    if (r_wrap) begin
                        pass_d = pass_q + 1'b1;
                    end
                    starve_d = '0;
                end else if (ps_elig) begin
                    starve_d = starve_q + 1'b1;
                end

                if (state_q == ST_RUN) begin
                    if (final_rd) begin
                        // Leave the job with pointers parked at 0 so the
                        // address outputs read 0 while idle.
                        state_d  = ST_IDLE;
                        pass_d   = '0;
                        wptr_d   = '0;
                        rptr_d   = '0;
                        wbit_d   = 1'b0;
                        rbit_d   = 1'b0;
                        starve_d = '0;
                    end else if (i_stall) begin
                        state_d = ST_STALL;
                    end
                end else if (!i_stall) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_inst_reset) begin
            state_d  = ST_IDLE;
            pass_d   = '0;
            wptr_d   = '0;
            rptr_d   = '0;
            wbit_d   = 1'b0;
            rbit_d   = 1'b0;
            starve_d = '0;
            rsel_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            size_q   <= (ADDRWD + 1)'(1);
            npass_q  <= PASSWD'(1);
            pass_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            wbit_q   <= 1'b0;
            rbit_q   <= 1'b0;
            starve_q <= '0;
            rsel_q   <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            npass_q  <= npass_d;
            pass_q   <= pass_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wbit_q   <= wbit_d;
            rbit_q   <= rbit_d;
            starve_q <= starve_d;
            rsel_q   <= rsel_d;
        end
    end

    always_comb begin
        MAIN_ack  = main_ack;
        SS_ack    = ss_ack;
        PS_ack    = ps_ack;
        o_rd      = main_ack || ps_ack;
        o_raddr   = main_ack ? i_main_raddr : (ps_ack ? rptr_q : '0);
        o_wr      = ss_ack;
        o_waddr   = wptr_q;
        o_rsel    = rsel_q;
        o_ps_addr = rptr_q;
        o_done    = done;
    end

endmodule

// File: tb/tb_ppad_port_sched.sv
// tb_ppad_port_sched: directed scenarios plus a randomized run of
// ppad_port_sched against a reference model that tracks total write and read
// counts (pointer = count mod size, occupancy = writes - reads).
module tb_ppad_port_sched;

    localparam int unsigned STARVE_MAX = 4;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1, i_inst_reset = 1'b0, i_stall = 1'b0, i_start = 1'b0;
    logic [5:0] i_size = '0;
    logic [7:0] i_npass = '0;
    logic       MAIN_rdy = 1'b0, SS_rdy = 1'b0, PS_rdy = 1'b0;
    logic [4:0] i_main_raddr = '0;
    logic       MAIN_ack, SS_ack, PS_ack, o_rd, o_wr, o_done;
    logic [4:0] o_raddr, o_waddr, o_ps_addr;
    logic [1:0] o_rsel;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit   m_job = 0, m_stall = 0;
    int   m_size = 1, m_npass = 1, m_wcnt = 0, m_rcnt = 0, m_starve = 0;
    logic [1:0] m_rsel = '0;

    // expected and observed values for the current cycle
    logic       e_main, e_ss, e_ps, e_elig, e_rd, e_wr, e_done;
    logic [4:0] e_raddr, e_waddr, e_psaddr;
    logic [1:0] e_rsel;
    logic       obs_main, obs_ss, obs_ps, obs_rd, obs_wr, obs_done;
    logic [4:0] obs_raddr, obs_waddr, obs_psaddr;
    logic [1:0] obs_rsel;

    always #5 clk = ~clk;

    ppad_port_sched #(.ADDRWD(5), .STARVE_MAX(STARVE_MAX), .PASSWD(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_inst_reset(i_inst_reset), .i_stall(i_stall),
        .i_start(i_start), .i_size(i_size), .i_npass(i_npass),
        .MAIN_rdy(MAIN_rdy), .MAIN_ack(MAIN_ack), .i_main_raddr(i_main_raddr),
        .SS_rdy(SS_rdy), .SS_ack(SS_ack), .PS_rdy(PS_rdy), .PS_ack(PS_ack),
        .o_rd(o_rd), .o_raddr(o_raddr), .o_wr(o_wr), .o_waddr(o_waddr),
        .o_rsel(o_rsel), .o_ps_addr(o_ps_addr), .o_done(o_done)
    );

    task automatic model_eval();
        int  occ;
        bit  run;
        occ    = m_wcnt - m_rcnt;
        run    = m_job && !m_stall;
        e_ss   = SS_rdy && run && (occ < m_size);
        e_elig = PS_rdy && run && (occ > 0);
        e_main = MAIN_rdy && !(e_elig && (m_starve >= int'(STARVE_MAX)));
        e_ps   = e_elig && !e_main;
        e_rd   = e_main || e_ps;
        e_wr   = e_ss;
        e_raddr  = e_main ? i_main_raddr : (e_ps ? 5'(m_rcnt % m_size) : 5'd0);
        e_waddr  = m_job ? 5'(m_wcnt % m_size) : 5'd0;
        e_psaddr = m_job ? 5'(m_rcnt % m_size) : 5'd0;
        e_done   = e_ps && (m_rcnt + 1 == m_size * m_npass) && !i_inst_reset;
        e_rsel   = m_rsel;
    endtask

    task automatic model_commit();
        m_rsel = (i_rst || i_inst_reset) ? 2'b00 : {e_ps, e_main};
        if (i_rst || i_inst_reset) begin
            m_job = 0; m_stall = 0; m_wcnt = 0; m_rcnt = 0; m_starve = 0;
        end else if (!m_job) begin
            m_starve = 0; m_wcnt = 0; m_rcnt = 0;
            if (i_start) begin
                m_job   = 1;
                m_stall = 0;
                m_size  = (i_size == 0) ? 1 : ((int'(i_size) > 32) ? 32 : int'(i_size));
                m_npass = (i_npass == 0) ? 1 : int'(i_npass);
            end
        end else if (e_done) begin
            m_job = 0; m_stall = 0; m_wcnt = 0; m_rcnt = 0; m_starve = 0;
        end else begin
            m_wcnt   = m_wcnt + int'(e_ss);
            m_rcnt   = m_rcnt + int'(e_ps);
            m_starve = e_ps ? 0 : (e_elig ? m_starve + 1 : m_starve);
            m_stall  = i_stall;
        end
    endtask

    // One clock: sample outputs at the falling edge, advance the model, step past the rising edge.
    task automatic run_cycle();
        @(negedge clk);
        model_eval();
        obs_main = MAIN_ack; obs_ss = SS_ack; obs_ps = PS_ack; obs_rd = o_rd; obs_wr = o_wr;
        obs_done = o_done; obs_raddr = o_raddr; obs_waddr = o_waddr; obs_psaddr = o_ps_addr;
        obs_rsel = o_rsel;
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_inst_reset = 0; i_stall = 0; i_start = 0; MAIN_rdy = 0; SS_rdy = 0; PS_rdy = 0;
    endtask

    task automatic start_job(input int size, input int npass);
        idle_inputs();
        i_start = 1; i_size = 6'(size); i_npass = 8'(npass);
        run_cycle();
        i_start = 0;
    endtask

    task automatic soft_reset();
        idle_inputs();
        i_inst_reset = 1;
        run_cycle();
        i_inst_reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 1; SS_rdy = 1; PS_rdy = 1;
        run_cycle();
        run_cycle();
        i_rst = 0; MAIN_rdy = 1; i_main_raddr = 5'd7;
        run_cycle();
        checks++; if (obs_rsel !== 2'b00) begin failures++; $display("FAIL reset_rsel got=%b exp=00", obs_rsel); end
        checks++; if (obs_ss !== 1'b0 || obs_ps !== 1'b0) begin failures++; $display("FAIL reset_idle_acks got=%b%b exp=00", obs_ss, obs_ps); end
        checks++; if (obs_main !== 1'b1 || obs_raddr !== 5'd7) begin failures++; $display("FAIL reset_idle_main got=%b/%0d exp=1/7", obs_main, obs_raddr); end
        checks++; if (obs_waddr !== 5'd0 || obs_psaddr !== 5'd0 || obs_done !== 1'b0) begin failures++; $display("FAIL reset_idle_outs got=%0d/%0d/%b exp=0/0/0", obs_waddr, obs_psaddr, obs_done); end
        MAIN_rdy = 0;
        run_cycle();
        checks++; if (obs_rsel !== 2'b01 || obs_rd !== 1'b0) begin failures++; $display("FAIL reset_rsel_main got=%b/%b exp=01/0", obs_rsel, obs_rd); end
    endtask

    task automatic test_fifo_basic();
        start_job(4, 1);
        SS_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            checks++; if (obs_ss !== 1'b1 || obs_wr !== 1'b1 || obs_waddr !== 5'(k)) begin failures++; $display("FAIL basic_write%0d got=%b/%0d exp=1/%0d", k, obs_ss, obs_waddr, k); end
        end
        SS_rdy = 0; PS_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            checks++; if (obs_ps !== 1'b1 || obs_raddr !== 5'(k) || obs_done !== (k == 3)) begin failures++; $display("FAIL basic_read%0d got=%b/%0d/%b exp=1/%0d/%b", k, obs_ps, obs_raddr, obs_done, k, (k == 3)); end
        end
        PS_rdy = 0; SS_rdy = 1;
        run_cycle();
        checks++; if (obs_ss !== 1'b0) begin failures++; $display("FAIL basic_idle_after_done got=%b exp=0", obs_ss); end
        SS_rdy = 0;
    endtask

    task automatic test_full();
        bit seen;
        start_job(2, 1);
        SS_rdy = 1;
        run_cycle();
        run_cycle();
        run_cycle();
        checks++; if (obs_ss !== 1'b0 || obs_wr !== 1'b0) begin failures++; $display("FAIL full_block got=%b/%b exp=0/0", obs_ss, obs_wr); end
        PS_rdy = 1;
        run_cycle();
        checks++; if (obs_ps !== 1'b1 || obs_raddr !== 5'd0 || obs_ss !== 1'b0) begin failures++; $display("FAIL full_drain_same got=%b/%0d/%b exp=1/0/0", obs_ps, obs_raddr, obs_ss); end
        PS_rdy = 0;
        run_cycle();
        checks++; if (obs_ss !== 1'b1 || obs_waddr !== 5'd0) begin failures++; $display("FAIL full_after_drain got=%b/%0d exp=1/0", obs_ss, obs_waddr); end
        SS_rdy = 0; PS_rdy = 1;
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            run_cycle();
            if (obs_done === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL full_done_timeout got=0 exp=1"); end
        PS_rdy = 0;
    endtask

    task automatic test_starve();
        start_job(8, 1);
        SS_rdy = 1;
        run_cycle();
        run_cycle();
        SS_rdy = 0; MAIN_rdy = 1; PS_rdy = 1; i_main_raddr = 5'h1a;
        for (int k = 0; k < 5; k++) begin
            run_cycle();
            if (k < 4) begin
                checks++; if (obs_main !== 1'b1 || obs_ps !== 1'b0 || obs_raddr !== 5'h1a) begin failures++; $display("FAIL starve_main%0d got=%b%b/%0h exp=10/1a", k, obs_main, obs_ps, obs_raddr); end
            end else begin
                checks++; if (obs_main !== 1'b0 || obs_ps !== 1'b1 || obs_raddr !== 5'd0) begin failures++; $display("FAIL starve_ps_forced got=%b%b/%0h exp=01/0", obs_main, obs_ps, obs_raddr); end
            end
        end
        PS_rdy = 0;
        run_cycle();
        checks++; if (obs_rsel !== 2'b10 || obs_main !== 1'b1) begin failures++; $display("FAIL starve_rsel got=%b/%b exp=10/1", obs_rsel, obs_main); end
        soft_reset();
    endtask

    task automatic test_empty_no_bypass();
        start_job(4, 1);
        SS_rdy = 1; PS_rdy = 1;
        run_cycle();
        checks++; if (obs_ss !== 1'b1 || obs_ps !== 1'b0) begin failures++; $display("FAIL empty_same_cycle got=%b%b exp=10", obs_ss, obs_ps); end
        SS_rdy = 0;
        run_cycle();
        checks++; if (obs_ps !== 1'b1 || obs_raddr !== 5'd0) begin failures++; $display("FAIL empty_next_cycle got=%b/%0d exp=1/0", obs_ps, obs_raddr); end
        soft_reset();
    endtask

    task automatic test_stall();
        start_job(8, 1);
        SS_rdy = 1;
        repeat (3) run_cycle();
        SS_rdy = 0; PS_rdy = 1;
        run_cycle();
        PS_rdy = 0; i_stall = 1;
        run_cycle();
        SS_rdy = 1; PS_rdy = 1; MAIN_rdy = 1; i_main_raddr = 5'd3;
        for (int k = 0; k < 2; k++) begin
            run_cycle();
            checks++; if (obs_ss !== 1'b0 || obs_ps !== 1'b0 || obs_main !== 1'b1) begin failures++; $display("FAIL stall_acks%0d got=%b%b%b exp=001", k, obs_ss, obs_ps, obs_main); end
            checks++; if (obs_waddr !== 5'd3 || obs_psaddr !== 5'd1) begin failures++; $display("FAIL stall_ptrs%0d got=%0d/%0d exp=3/1", k, obs_waddr, obs_psaddr); end
        end
        SS_rdy = 0; PS_rdy = 0; MAIN_rdy = 0; i_stall = 0;
        run_cycle();
        SS_rdy = 1;
        run_cycle();
        checks++; if (obs_ss !== 1'b1 || obs_waddr !== 5'd3) begin failures++; $display("FAIL stall_resume_ss got=%b/%0d exp=1/3", obs_ss, obs_waddr); end
        SS_rdy = 0; PS_rdy = 1;
        run_cycle();
        checks++; if (obs_ps !== 1'b1 || obs_raddr !== 5'd1) begin failures++; $display("FAIL stall_resume_ps got=%b/%0d exp=1/1", obs_ps, obs_raddr); end
        soft_reset();
    endtask

    task automatic test_inst_reset();
        start_job(8, 1);
        SS_rdy = 1;
        repeat (3) run_cycle();
        SS_rdy = 0; PS_rdy = 1; i_inst_reset = 1;
        run_cycle();
        checks++; if (obs_done !== 1'b0) begin failures++; $display("FAIL inst_reset_done got=%b exp=0", obs_done); end
        i_inst_reset = 0; PS_rdy = 0; SS_rdy = 1;
        run_cycle();
        checks++; if (obs_ss !== 1'b0 || obs_waddr !== 5'd0 || obs_rsel !== 2'b00) begin failures++; $display("FAIL inst_reset_idle got=%b/%0d/%b exp=0/0/00", obs_ss, obs_waddr, obs_rsel); end
        i_start = 1; i_size = 6'd8; i_npass = 8'd1;
        run_cycle();
        i_start = 0;
        run_cycle();
        checks++; if (obs_ss !== 1'b1 || obs_waddr !== 5'd0) begin failures++; $display("FAIL inst_reset_restart got=%b/%0d exp=1/0", obs_ss, obs_waddr); end
        soft_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            i_rst        = ($urandom_range(0, 499) == 0);
            i_inst_reset = ($urandom_range(0, 199) == 0);
            i_stall      = ($urandom_range(0, 9) == 0);
            i_start      = ($urandom_range(0, 3) == 0);
            i_size       = 6'($urandom_range(0, 40));
            i_npass      = 8'($urandom_range(0, 3));
            MAIN_rdy     = ($urandom_range(0, 2) != 0);
            SS_rdy       = ($urandom_range(0, 1) == 0);
            PS_rdy       = ($urandom_range(0, 4) < 3);
            i_main_raddr = 5'($urandom);
            run_cycle();
            checks++; if ({obs_main, obs_ss, obs_ps} !== {e_main, e_ss, e_ps}) begin failures++; $display("FAIL rand_acks cyc=%0d got=%b%b%b exp=%b%b%b", n, obs_main, obs_ss, obs_ps, e_main, e_ss, e_ps); end
            checks++; if (obs_rd !== e_rd || obs_raddr !== e_raddr) begin failures++; $display("FAIL rand_read cyc=%0d got=%b/%0d exp=%b/%0d", n, obs_rd, obs_raddr, e_rd, e_raddr); end
            checks++; if (obs_wr !== e_wr || obs_waddr !== e_waddr) begin failures++; $display("FAIL rand_write cyc=%0d got=%b/%0d exp=%b/%0d", n, obs_wr, obs_waddr, e_wr, e_waddr); end
            checks++; if (obs_psaddr !== e_psaddr || obs_rsel !== e_rsel || obs_done !== e_done) begin failures++; $display("FAIL rand_misc cyc=%0d got=%0d/%b/%b exp=%0d/%b/%b", n, obs_psaddr, obs_rsel, obs_done, e_psaddr, e_rsel, e_done); end
        end
        i_rst = 0;
        soft_reset();
    endtask

    initial begin
        #1;
        test_reset();
        test_fifo_basic();
        test_full();
        test_starve();
        test_empty_no_bypass();
        test_stall();
        test_inst_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
